traffic_light: RTL and testbench



---
 rtl/traffic_light.sv | 159 +++++++++++++++
 tb/tb_traffic_light.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// ---------------------------------------------------------------------------
// traffic_light
//
// Free-running single-head traffic-light sequencer. Cycles RED -> GREEN ->
// YELLOW -> RED, holding each aspect for a fixed number of clock cycles.
//
// Parameters
//   RED_TIME    : red dwell in cycles    (1 .. 2**CNT_W)
//   GREEN_TIME  : green dwell in cycles  (1 .. 2**CNT_W)
//   YELLOW_TIME : yellow dwell in cycles (1 .. 2**CNT_W)
//   CNT_W       : dwell counter width
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (release is synchronized)
//   red       out  red lamp (registered)
//   yellow    out  yellow lamp (registered)
//   green     out  green lamp (registered)
//   phase     out  2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW (registered)
//   remaining out  cycles left in the current phase, including this one
// ---------------------------------------------------------------------------
module traffic_light #(
  parameter int RED_TIME    = 4,
  parameter int GREEN_TIME  = 3,
  parameter int YELLOW_TIME = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  // Durations and terminal counts in counter width. A duration of exactly
  // 2**CNT_W still counts correctly (terminal count fits), but its
  // remaining value wraps to 0 in the first cycle of that phase.
  localparam logic [CNT_W-1:0] RED_N     = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] GREEN_N   = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] YELLOW_N  = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] RED_M1    = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TIME - 1);

  if (RED_TIME < 1 || RED_TIME > (2 ** CNT_W)) begin : g_red_range_chk
    $error("traffic_light: RED_TIME out of range 1..2**CNT_W");
  end
  if (GREEN_TIME < 1 || GREEN_TIME > (2 ** CNT_W)) begin : g_green_range_chk
    $error("traffic_light: GREEN_TIME out of range 1..2**CNT_W");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > (2 ** CNT_W)) begin : g_yellow_range_chk
    $error("traffic_light: YELLOW_TIME out of range 1..2**CNT_W");
  end

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_red;
  logic             r_yellow;
  logic             r_green;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_dur;
  logic             w_run;

  // Release synchronizer: assertion is immediate, deassertion takes two
  // edges. The FSM holds in RED/0 until r_sync[1] has been seen high, so the
  // first full RED dwell begins at the second edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_run = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RED;
      r_cnt    <= '0;
      r_red    <= 1'b1;
      r_yellow <= 1'b0;
      r_green  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      // Lamps decoded from the next state so they flip on the same edge
      // as the phase itself.
      r_red    <= (w_state_next == ST_RED);
      r_yellow <= (w_state_next == ST_YELLOW);
      r_green  <= (w_state_next == ST_GREEN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dur        = RED_N;
    case (r_state)
      ST_RED: begin
        w_dur = RED_N;
        if (w_run) begin
          if (r_cnt == RED_M1) begin
            w_state_next = ST_GREEN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_GREEN: begin
        w_dur = GREEN_N;
        if (w_run) begin
          if (r_cnt == GREEN_M1) begin
            w_state_next = ST_YELLOW;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_YELLOW: begin
        w_dur = YELLOW_N;
        if (w_run) begin
          if (r_cnt == YELLOW_M1) begin
            w_state_next = ST_RED;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        // Unused encoding (upset): recover to the start of RED.
        w_dur        = RED_N;
        w_state_next = ST_RED;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign red       = r_red;
  assign yellow    = r_yellow;
  assign green     = r_green;
  assign phase     = r_state;
  assign remaining = w_dur - r_cnt;

endmodule

// File: tb/tb_traffic_light.sv
// ---------------------------------------------------------------------------
// tb_traffic_light
//
// Directed bench for traffic_light. Three instances share clock and reset:
//   u_def : default timing (4/3/2, CNT_W=8)
//   u_min : all dwells 1
//   u_nar : CNT_W=2 with RED_TIME=3 (3/3/2)
// ---------------------------------------------------------------------------
module tb_traffic_light;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       d_red, d_yel, d_grn;
  logic [1:0] d_ph;
  logic [7:0] d_rem;
  logic       m_red, m_yel, m_grn;
  logic [1:0] m_ph;
  logic [7:0] m_rem;
  logic       n_red, n_yel, n_grn;
  logic [1:0] n_ph;
  logic [1:0] n_rem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light u_def (
    .clk(clk), .rst_n(rst_n), .red(d_red), .yellow(d_yel), .green(d_grn),
    .phase(d_ph), .remaining(d_rem)
  );

  traffic_light #(.RED_TIME(1), .GREEN_TIME(1), .YELLOW_TIME(1)) u_min (
    .clk(clk), .rst_n(rst_n), .red(m_red), .yellow(m_yel), .green(m_grn),
    .phase(m_ph), .remaining(m_rem)
  );

  traffic_light #(.CNT_W(2), .RED_TIME(3)) u_nar (
    .clk(clk), .rst_n(rst_n), .red(n_red), .yellow(n_yel), .green(n_grn),
    .phase(n_ph), .remaining(n_rem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {red, yellow, green} expected for a given phase code
  function automatic logic [2:0] lamp_of(input int ph);
    case (ph)
      0:       lamp_of = 3'b100;
      1:       lamp_of = 3'b001;
      default: lamp_of = 3'b010;
    endcase
  endfunction

  int def_ph[9]  = '{0, 0, 0, 0, 1, 1, 1, 2, 2};
  int def_rem[9] = '{4, 3, 2, 1, 3, 2, 1, 2, 1};
  int nar_ph[8]  = '{0, 0, 0, 1, 1, 1, 2, 2};
  int nar_rem[8] = '{3, 2, 1, 3, 2, 1, 2, 1};

  task automatic check_reset_state(input string tag);
    check({tag, "_def_lamps"}, 32'({d_red, d_yel, d_grn}), 32'(3'b100));
    check({tag, "_def_phase"}, 32'(d_ph), 32'd0);
    check({tag, "_def_rem"},   32'(d_rem), 32'd4);
    check({tag, "_min_lamps"}, 32'({m_red, m_yel, m_grn}), 32'(3'b100));
    check({tag, "_min_rem"},   32'(m_rem), 32'd1);
    check({tag, "_nar_rem"},   32'(n_rem), 32'd3);
  endtask

  initial begin
    bit found;

    // Create a real falling edge so the asynchronous reset is exercised.
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    $display("reset asserted: lamps=%b phase=%0d rem=%0d", {d_red, d_yel, d_grn}, d_ph, d_rem);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_reset_state("rst_hold");
      $display("reset cycle %0d: lamps=%b phase=%0d rem=%0d", c, {d_red, d_yel, d_grn}, d_ph, d_rem);
    end

    // Release between edges; the RED dwell starts at the second edge.
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;

    for (int i = 0; i < 108; i++) begin
      check("seq_def_lamps", 32'({d_red, d_yel, d_grn}), 32'(lamp_of(def_ph[i % 9])));
      check("seq_def_phase", 32'(d_ph), 32'(def_ph[i % 9]));
      check("seq_def_rem",   32'(d_rem), 32'(def_rem[i % 9]));
      check("onehot_def",    32'(d_red) + 32'(d_yel) + 32'(d_grn), 32'd1);
      check("phase11_def",   32'(d_ph == 2'b11), 32'd0);
      check("seq_min_lamps", 32'({m_red, m_yel, m_grn}), 32'(lamp_of(i % 3)));
      check("seq_min_rem",   32'(m_rem), 32'd1);
      check("seq_nar_phase", 32'(n_ph), 32'(nar_ph[i % 8]));
      check("seq_nar_rem",   32'(n_rem), 32'(nar_rem[i % 8]));
      $display("cycle %0d: def lamps=%b rem=%0d | min lamps=%b | nar phase=%0d rem=%0d",
               i, {d_red, d_yel, d_grn}, d_rem, {m_red, m_yel, m_grn}, n_ph, n_rem);
      @(posedge clk); #1;
    end

    // Reach GREEN on the default instance, then reset halfway to the next edge.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (d_ph == 2'b01) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("wait_green", 32'(found), 32'd1);

    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_lamps", 32'({d_red, d_yel, d_grn}), 32'(3'b100));
    check("mid_rst_phase", 32'(d_ph), 32'd0);
    check("mid_rst_rem",   32'(d_rem), 32'd4);
    $display("mid-green reset: lamps=%b phase=%0d rem=%0d", {d_red, d_yel, d_grn}, d_ph, d_rem);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;

    for (int j = 0; j < 5; j++) begin
      check("post_rst_phase", 32'(d_ph), 32'(def_ph[j]));
      check("post_rst_rem",   32'(d_rem), 32'(def_rem[j]));
      $display("post-reset cycle %0d: lamps=%b phase=%0d rem=%0d", j, {d_red, d_yel, d_grn}, d_ph, d_rem);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
